// File: rtl/breath_pkg.sv
// breath_pkg: shared widths, channel state enum and the gamma helper for
// the breath_scheduler slice.
package breath_pkg;

  localparam int PWM_BITS  = 6;
  localparam int LUT_DEPTH = 64;

  // Per-channel life cycle: OFF (dark, idle), RUN (breathing), DRAIN (enable
  // dropped, still breathing down until the next trough).
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ch_state_e;

  // Square-law perceptual correction: (d*d)>>6 with a full 12-bit product,
  // so the result spans 0..62.
  function automatic logic [PWM_BITS-1:0] gamma_correct(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] prod;
    prod = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
    return prod[2*PWM_BITS-1:PWM_BITS];
  endfunction

endpackage

// File: rtl/sine_lut_64.sv
// sine_lut_64: combinational 64-entry raised-sine duty table, 6-bit in/out.
// The table is symmetric (entry k == entry 63-k), so only the rising half
// is stored and the falling half is addressed by inverting the low bits.
module sine_lut_64
  import breath_pkg::*;
(
  input  logic [PWM_BITS-1:0] i_addr,
  output logic [PWM_BITS-1:0] o_duty
);

  logic [PWM_BITS-2:0] w_half;

  // Fold the upper half of the address space onto the stored rising half.
  always_comb begin
    w_half = i_addr[PWM_BITS-1] ? ~i_addr[PWM_BITS-2:0] : i_addr[PWM_BITS-2:0];
  end

  // Rising half of the raised sine: 0 at the trough, 63 at the crest.
  always_comb begin
    o_duty = '0;
    case (w_half)
      5'd0:  o_duty = 6'd0;
      5'd1:  o_duty = 6'd0;
      5'd2:  o_duty = 6'd1;
      5'd3:  o_duty = 6'd2;
      5'd4:  o_duty = 6'd3;
      5'd5:  o_duty = 6'd5;
      5'd6:  o_duty = 6'd7;
      5'd7:  o_duty = 6'd9;
      5'd8:  o_duty = 6'd11;
      5'd9:  o_duty = 6'd13;
      5'd10: o_duty = 6'd16;
      5'd11: o_duty = 6'd19;
      5'd12: o_duty = 6'd21;
      5'd13: o_duty = 6'd24;
      5'd14: o_duty = 6'd27;
      5'd15: o_duty = 6'd30;
      5'd16: o_duty = 6'd33;
      5'd17: o_duty = 6'd36;
      5'd18: o_duty = 6'd39;
      5'd19: o_duty = 6'd42;
      5'd20: o_duty = 6'd45;
      5'd21: o_duty = 6'd48;
      5'd22: o_duty = 6'd51;
      5'd23: o_duty = 6'd53;
      5'd24: o_duty = 6'd55;
      5'd25: o_duty = 6'd57;
      5'd26: o_duty = 6'd59;
      5'd27: o_duty = 6'd60;
      5'd28: o_duty = 6'd61;
      5'd29: o_duty = 6'd62;
      5'd30: o_duty = 6'd63;
      5'd31: o_duty = 6'd63;
      default: o_duty = '0;
    endcase
  end

endmodule

// File: rtl/breath_scheduler.sv
// breath_scheduler: multi-channel breathing-LED PWM controller.
// One shared sine table is read in per-channel fetch slots (count==i) into
// shadow registers; all duties swap in together at the period boundary
// (count==63), so a duty never changes mid-period. Channels are phase
// staggered by 64/CHANNELS table entries.
// Optional feature macro: BREATH_GAMMA_EN (square-law correct fetched duty).
// Handshake: none. enable is a level input sampled only at boundary edges;
// pulse/busy are decoded from registers only.
module breath_scheduler
  import breath_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int STEP_DIV = 1
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      enable,
  output logic [CHANNELS-1:0]      pulse,
  output logic [CHANNELS-1:0]      busy,
  output logic [CHANNELS-1:0][1:0] o_dbg_state
);

  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIV_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PHASE_STEP = LUT_DEPTH / CHANNELS;
  localparam logic [PWM_BITS-1:0] SLOT_END  = PWM_BITS'(CHANNELS);
  localparam logic [PWM_BITS-1:0] COUNT_MAX = PWM_BITS'(LUT_DEPTH - 1);
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] r_count;
  logic [PWM_BITS-1:0] r_idx;
  logic [DIV_W-1:0]    r_div;
  logic [PWM_BITS-1:0] r_shadow [CHANNELS];
  logic [PWM_BITS-1:0] r_duty   [CHANNELS];
  ch_state_e           r_state  [CHANNELS];
  ch_state_e           w_next   [CHANNELS];

  logic                w_bound;
  logic                w_slot;
  logic [CH_W-1:0]     w_ch;
  logic [PWM_BITS-1:0] w_addr;
  logic [PWM_BITS-1:0] w_lut;
  logic [PWM_BITS-1:0] w_fetch;

  assign w_bound = (r_count == COUNT_MAX);
  assign w_slot  = (r_count < SLOT_END);
  assign w_ch    = r_count[CH_W-1:0];
  // Address wraps naturally modulo 64 in the 6-bit add.
  assign w_addr  = r_idx + PWM_BITS'(int'(w_ch) * PHASE_STEP);

  sine_lut_64 u_lut (
    .i_addr (w_addr),
    .o_duty (w_lut)
  );

`ifdef BREATH_GAMMA_EN
  assign w_fetch = gamma_correct(w_lut);
`else
  assign w_fetch = w_lut;
`endif

  // PWM counter, step divider and global table index.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_count <= '0;
      r_div   <= '0;
      r_idx   <= '0;
    end else begin
      r_count <= r_count + PWM_BITS'(1);
      if (w_bound) begin
        if (r_div == DIV_LAST) begin
          r_div <= '0;
          r_idx <= r_idx + PWM_BITS'(1);
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
    end
  end

  // Fetch into the slot's shadow; publish all shadows as duties at the boundary.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_duty[i]   <= '0;
      end
    end else begin
      if (w_slot) r_shadow[w_ch] <= w_fetch;
      if (w_bound) begin
        for (int i = 0; i < CHANNELS; i++) r_duty[i] <= r_shadow[i];
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) r_state[i] <= OFF;
    end else begin
      for (int i = 0; i < CHANNELS; i++) r_state[i] <= w_next[i];
    end
  end

  // Next state: moves only at the boundary; DRAIN ends on a zero shadow,
  // but a re-asserted enable takes priority and resumes RUN.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_next[i] = r_state[i];
      if (w_bound) begin
        case (r_state[i])
          OFF:     if (enable[i]) w_next[i] = RUN;
          RUN:     if (!enable[i]) w_next[i] = DRAIN;
          DRAIN: begin
            if (enable[i])                w_next[i] = RUN;
            else if (r_shadow[i] == '0)   w_next[i] = OFF;
          end
          default: w_next[i] = OFF;
        endcase
      end
    end
  end

  // Outputs decoded purely from state, counter and duty registers.
  always_comb begin
    pulse       = '0;
    busy        = '0;
    o_dbg_state = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i]        = (r_state[i] != OFF);
      pulse[i]       = (r_state[i] != OFF) && (r_count < r_duty[i]);
      o_dbg_state[i] = r_state[i];
    end
  end

endmodule

// File: tb/tb_breath_scheduler.sv
// tb_breath_scheduler: directed bench for breath_scheduler. Two instances
// share clock and reset: u_dut_a (STEP_DIV=1, driven through enable fades)
// and u_dut_b (STEP_DIV=3, always enabled). Per-period high and busy counts
// are compared against a hand-typed duty table.
`timescale 1ns/1ps
module tb_breath_scheduler;
  import breath_pkg::*;

  localparam int CH = 4;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic rst;
  always #5 sysclk = ~sysclk;

  logic [CH-1:0]      en_a, en_b;
  logic [CH-1:0]      pulse_a, pulse_b, busy_a, busy_b;
  logic [CH-1:0][1:0] st_a, st_b;

  breath_scheduler #(.CHANNELS(CH), .STEP_DIV(1)) u_dut_a (
    .sysclk      (sysclk),
    .rst         (rst),
    .enable      (en_a),
    .pulse       (pulse_a),
    .busy        (busy_a),
    .o_dbg_state (st_a)
  );

  breath_scheduler #(.CHANNELS(CH), .STEP_DIV(3)) u_dut_b (
    .sysclk      (sysclk),
    .rst         (rst),
    .enable      (en_b),
    .pulse       (pulse_b),
    .busy        (busy_b),
    .o_dbg_state (st_b)
  );

  // ---------------- reference table ----------------
  localparam int LUT_REF [64] = '{
     0,  0,  1,  2,  3,  5,  7,  9, 11, 13, 16, 19, 21, 24, 27, 30,
    33, 36, 39, 42, 45, 48, 51, 53, 55, 57, 59, 60, 61, 62, 63, 63,
    63, 63, 62, 61, 60, 59, 57, 55, 53, 51, 48, 45, 42, 39, 36, 33,
    30, 27, 24, 21, 19, 16, 13, 11,  9,  7,  5,  3,  2,  1,  0,  0
  };

  function automatic int exp_duty(input int addr);
    int d;
    d = LUT_REF[addr % 64];
`ifdef BREATH_GAMMA_EN
    d = (d * d) >> 6;
`endif
    return d;
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver / monitor tasks ----------------
  int hc_a [CH];
  int hc_b [CH];
  int bc_a [CH];
  int bc_b [CH];

  // Sample one 64-cycle PWM period starting at the current negedge (count==0).
  // With glitch set, enable[2] of instance a drops for cycles 10..19.
  task automatic run_period(input bit glitch);
    for (int c = 0; c < CH; c++) begin
      hc_a[c] = 0; hc_b[c] = 0; bc_a[c] = 0; bc_b[c] = 0;
    end
    for (int k = 0; k < 64; k++) begin
      if (glitch && k == 10) en_a[2] = 1'b0;
      if (glitch && k == 20) en_a[2] = 1'b1;
      for (int c = 0; c < CH; c++) begin
        hc_a[c] += int'(pulse_a[c]);
        hc_b[c] += int'(pulse_b[c]);
        bc_a[c] += int'(busy_a[c]);
        bc_b[c] += int'(busy_b[c]);
      end
      @(negedge sysclk);
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge sysclk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CH-1:0] acc_p, acc_b;
    int off_q;
    bit act;

    rst  = 1'b1;
    en_a = '0;
    en_b = '0;
    apply_reset(4);
    check("rst_pulse_a", pulse_a, 0);
    check("rst_busy_a",  busy_a,  0);
    check("rst_state_a", st_a,    {CH{OFF}});
    check("rst_pulse_b", pulse_b, 0);

    // Idle after reset with all enables low: nothing may light.
    rst   = 1'b0;
    acc_p = '0;
    acc_b = '0;
    for (int k = 0; k < 200; k++) begin
      acc_p |= pulse_a | pulse_b;
      acc_b |= busy_a | busy_b;
      @(negedge sysclk);
    end
    check("idle_pulse", acc_p, 0);
    check("idle_busy",  acc_b, 0);

    // Main run: enables high from reset release; release edge is cycle 0.
    apply_reset(2);
    en_a = '1;
    en_b = '1;
    rst  = 1'b0;

    // Channel 0 is dropped during period 40; it goes dark from the period after
    // the first boundary (q>=41) whose loaded value is zero.
    off_q = 63;
    for (int q = 63; q >= 41; q--) if (exp_duty(q) == 0) off_q = q;

    for (int p = 0; p <= 70; p++) begin
      if (p == 40) begin
        en_a[0] = 1'b0;
        en_a[1] = 1'b0;
      end
      if (p == 41) en_a[1] = 1'b1;
      run_period(p == 2);

      for (int c = 0; c < CH; c++) begin
        act = (p >= 1) && !(c == 0 && p > off_q);
        exp_q.push_back(act ? exp_duty(p - 1 + 16 * c) : 0);
        exp_q.push_back(act ? 64 : 0);
      end
      for (int c = 0; c < CH; c++) begin
        check($sformatf("a_high_p%0d_ch%0d", p, c), hc_a[c], exp_q.pop_front());
        check($sformatf("a_busy_p%0d_ch%0d", p, c), bc_a[c], exp_q.pop_front());
      end

      if (p <= 9) begin
        for (int c = 0; c < CH; c++) begin
          act = (p >= 1);
          check($sformatf("b_high_p%0d_ch%0d", p, c), hc_b[c],
                act ? exp_duty((p - 1) / 3 + 16 * c) : 0);
          check($sformatf("b_busy_p%0d_ch%0d", p, c), bc_b[c], act ? 64 : 0);
        end
      end

      // Now at cycle 0 of period p+1: state reflects the boundary just taken.
      if (p == 40) check("st0_drain", st_a[0], DRAIN);
      if (p == 41) check("st1_rerun", st_a[1], RUN);
      if (p == off_q) check("st0_off", st_a[0], OFF);
    end

    // Reset asserted at cycle 100 of a running test clears outputs next edge.
    apply_reset(2);
    en_a = '1;
    rst  = 1'b0;
    repeat (100) @(negedge sysclk);
    check("pre_rst_pulse", pulse_a, 4'b0100);
    check("pre_rst_busy",  busy_a,  4'b1111);
    rst = 1'b1;
    @(negedge sysclk);
    check("mid_rst_pulse_a", pulse_a, 0);
    check("mid_rst_busy_a",  busy_a,  0);
    check("mid_rst_state_a", st_a,    {CH{OFF}});
    check("mid_rst_busy_b",  busy_b,  0);
    rst = 1'b0;

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
